rgbled_frame_seq: RTL and testbench

//  Frame sequencer sitting directly upstream of ws281x_drv. Holds per-LED colour registers,

---
 rtl/rgbled_pkg.sv | 19 +
 rtl/rgbled_frame_seq.sv | 129 ++++++++++++
 tb/tb_rgbled_frame_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgbled_pkg.sv
// Shared types for the RGB LED frame sequencer: colour word layout and FSM states.
package rgbled_pkg;

   // Field order matches WS281x wire order: G first, then R, then B.
   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2
   } rgbled_state_e;

   localparam rgb_t RGB_OFF = '0;

endpackage

// File: rtl/rgbled_frame_seq.sv
// Frame sequencer feeding ws281x_drv: shadow/active colour registers, periodic refresh,
// and one 24-bit word per LED over a valid/ack handshake with data_last on the final word.
module rgbled_frame_seq
   import rgbled_pkg::*;
#(
   parameter int unsigned NumLeds       = 2,
   parameter int unsigned RefreshCycles = 500_000,
   localparam int unsigned IdxW         = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
   input  logic            main_clk_buf,
   input  logic            rst_sys_n,
   input  logic            wr_en_i,
   input  logic [IdxW-1:0] wr_idx_i,
   input  logic [23:0]     wr_data_i,
   input  logic            update_i,
   input  logic            off_i,
   output logic            go_o,
   output logic [23:0]     data_o,
   output logic            data_valid_o,
   output logic            data_last_o,
   input  logic            data_ack_i,
   input  logic            drv_idle_i,
   output logic            busy_o
);

   localparam int unsigned CntW = (RefreshCycles > 1) ? $clog2(RefreshCycles) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(RefreshCycles - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NumLeds - 1);

   rgbled_state_e   state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pending_q, pending_d;
   logic            busy_q, busy_d;
   rgb_t            shadow_q [NumLeds];
   rgb_t            shadow_d [NumLeds];
   rgb_t            active_q [NumLeds];
   rgb_t            active_d [NumLeds];

   logic tick;
   logic commit;
   logic word_last;

   assign tick      = (cnt_q == CntLast);
   assign word_last = (idx_q == IdxLast);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = tick ? '0 : cnt_q + CntW'(1);
      shadow_d  = shadow_q;
      active_d  = active_q;
      commit    = 1'b0;

      if (wr_en_i && (32'(wr_idx_i) < NumLeds)) begin
         shadow_d[wr_idx_i] = wr_data_i;
      end

      unique case (state_q)
         IDLE: begin
            if ((tick || pending_q) && drv_idle_i) begin
               if (pending_q) begin
                  active_d = shadow_q;
                  commit   = 1'b1;
               end
               idx_d   = '0;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (data_ack_i) begin
               if (word_last) begin
                  state_d = DRAIN;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         DRAIN: begin
            if (drv_idle_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A pulse coinciding with a commit re-arms pending: the commit copied the
      // shadow as it stood before this cycle's write.
      pending_d = update_i | (pending_q & ~commit);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         shadow_q  <= '{default: RGB_OFF};
         active_q  <= '{default: RGB_OFF};
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
      end
   end

   always_comb begin
      go_o         = 1'b0;
      data_valid_o = 1'b0;
      data_last_o  = 1'b0;
      data_o       = RGB_OFF;
      if (state_q == SEND) begin
         go_o         = 1'b1;
         data_valid_o = 1'b1;
         data_last_o  = word_last;
         data_o       = off_i ? RGB_OFF : active_q[idx_q];
      end
   end

   assign busy_o = busy_q;

endmodule

// File: tb/tb_rgbled_frame_seq.sv
// Scoreboard bench for rgbled_frame_seq with a behavioural ws281x_drv handshake model.
module tb_rgbled_frame_seq;
   import rgbled_pkg::*;

   localparam int unsigned NLEDS = 3;
   localparam int unsigned RC    = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [1:0]  wr_idx;
   logic [23:0] wr_data;
   logic        update;
   logic        off;
   logic        go;
   logic [23:0] data;
   logic        data_valid;
   logic        data_last;
   logic        data_ack;
   logic        drv_idle;
   logic        busy;
   logic        hold_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] data;
      logic        last;
   } exp_t;
   exp_t exp_q[$];

   rgbled_frame_seq #(
      .NumLeds      (NLEDS),
      .RefreshCycles(RC)
   ) dut (
      .main_clk_buf(clk),
      .rst_sys_n   (rst_n),
      .wr_en_i     (wr_en),
      .wr_idx_i    (wr_idx),
      .wr_data_i   (wr_data),
      .update_i    (update),
      .off_i       (off),
      .go_o        (go),
      .data_o      (data),
      .data_valid_o(data_valid),
      .data_last_o (data_last),
      .data_ack_i  (data_ack),
      .drv_idle_i  (drv_idle),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2);
      exp_q.push_back('{data: w0, last: 1'b0});
      exp_q.push_back('{data: w1, last: 1'b0});
      exp_q.push_back('{data: w2, last: 1'b1});
   endtask

   task automatic wait_busy(input logic lvl, input int budget, input string name);
      int n = 0;
      while (busy !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy !== lvl) begin
         checks++;
         errors++;
         $display("FAIL %s: busy=%b expected %b within %0d cycles", name, busy, lvl, budget);
      end
   endtask

   task automatic frame_done(input string name);
      wait_busy(1'b1, 400, name);
      wait_busy(1'b0, 100, name);
   endtask

   // Driver model: ack 3 cycles after valid, idle 10 cycles after the last ack.
   initial begin : drv_model
      int cnt;
      int gap;
      logic ack_last;
      cnt = 0; gap = 0; ack_last = 1'b0;
      data_ack = 1'b0;
      drv_idle = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            data_ack = 1'b0; drv_idle = 1'b1; cnt = 0; gap = 0; ack_last = 1'b0;
         end else if (data_ack) begin
            data_ack = 1'b0;
            if (ack_last) gap = 10;
         end else if (data_valid) begin
            drv_idle = 1'b0;
            if (!hold_ack) begin
               cnt++;
               if (cnt == 3) begin
                  data_ack = 1'b1;
                  cnt      = 0;
                  ack_last = data_last;
               end
            end
         end else if (gap > 0) begin
            gap--;
            if (gap == 0) drv_idle = 1'b1;
         end
      end
   end

   // Monitor: every accepted word is compared against the head of the queue.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && data_valid && data_ack) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h expected none", data);
            end else begin
               e = exp_q.pop_front();
               check("word_data", 32'(data), 32'(e.data));
               check("word_last", 32'(data_last), 32'(e.last));
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; update = 1'b0; off = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_go", 32'(go), 32'd0);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_last", 32'(data_last), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      // 1: first refresh frame carries all-zero words
      push_frame(24'h000000, 24'h000000, 24'h000000);
      frame_done("t1_frame");

      // 2: write colours, commit, check 2-cycle latency
      @(negedge clk); wr_en = 1'b1; wr_idx = 2'd0; wr_data = 24'h00FF00;
      @(negedge clk); wr_idx = 2'd1; wr_data = 24'h0000FF;
      @(negedge clk); wr_en = 1'b0; update = 1'b1;
      push_frame(24'h00FF00, 24'h0000FF, 24'h000000);
      @(negedge clk); update = 1'b0;
      check("t2_latency_c1", 32'(data_valid), 32'd0);
      @(negedge clk);
      check("t2_latency_c2", 32'(data_valid), 32'd1);
      frame_done("t2_frame");

      // 3: update during word 0 must not tear the current frame
      push_frame(24'h00FF00, 24'h0000FF, 24'h000000);
      wait_busy(1'b1, 400, "t3_start");
      wr_en = 1'b1; wr_idx = 2'd1; wr_data = 24'h123456; update = 1'b1;
      push_frame(24'h00FF00, 24'h123456, 24'h000000);
      @(negedge clk); wr_en = 1'b0; update = 1'b0;
      wait_busy(1'b0, 100, "t3_end_n");
      wait_busy(1'b1, 2, "t3_back_to_back");
      wait_busy(1'b0, 100, "t3_end_n1");

      // 4: off_i blanks the frame without touching active colours
      off = 1'b1;
      push_frame(24'h000000, 24'h000000, 24'h000000);
      frame_done("t4_off");
      off = 1'b0;
      push_frame(24'h00FF00, 24'h123456, 24'h000000);
      frame_done("t4_restore");

      // 5: out-of-range write ignored; same-cycle write+update included
      @(negedge clk); wr_en = 1'b1; wr_idx = 2'd3; wr_data = 24'hABCDEF;
      @(negedge clk); wr_idx = 2'd2; wr_data = 24'h654321; update = 1'b1;
      push_frame(24'h00FF00, 24'h123456, 24'h654321);
      @(negedge clk); wr_en = 1'b0; update = 1'b0;
      frame_done("t5_frame");

      // 6: reset mid-frame with ack withheld
      hold_ack = 1'b1;
      wait_busy(1'b1, 400, "t6_start");
      repeat (5) @(negedge clk);
      check("t6_hold_valid", 32'(data_valid), 32'd1);
      check("t6_hold_go", 32'(go), 32'd1);
      check("t6_hold_data", 32'(data), 32'h00FF00);
      check("t6_hold_last", 32'(data_last), 32'd0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_go", 32'(go), 32'd0);
      check("t6_rst_valid", 32'(data_valid), 32'd0);
      check("t6_rst_last", 32'(data_last), 32'd0);
      check("t6_rst_data", 32'(data), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      hold_ack = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); update = 1'b1;
      push_frame(24'h000000, 24'h000000, 24'h000000);
      @(negedge clk); update = 1'b0;
      frame_done("t6_zeroed");

      repeat (5) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
